// File: rtl/perf_pkg.sv
// perf_pkg: shared state enum, widths and the wrap/saturate accumulate helper for the perf counter bank
package perf_pkg;

    localparam int STAMP_W = 64;
    localparam int ACC_W   = 64;

    typedef enum logic {
        IDLE,
        DUMP
    } dump_state_e;

    typedef struct packed {
        logic             carry;
        logic [ACC_W-1:0] sum;
    } acc_res_t;

    // Adds two operands that fit in w bits. carry is bit w of the true sum.
    // With sat set, a carry clamps the result to all-ones in w bits.
    // Otherwise the result wraps modulo 2^w.
    function automatic acc_res_t acc_add(
        input logic [ACC_W-1:0] a,
        input logic [ACC_W-1:0] b,
        input int unsigned      w,
        input logic             sat
    );
        logic [ACC_W:0]   full;
        logic [ACC_W-1:0] mask;
        acc_res_t         r;
        full    = {1'b0, a} + {1'b0, b};
        mask    = (w >= ACC_W) ? '1 : ((ACC_W'(1) << w) - ACC_W'(1));
        r.carry = full[w];
        r.sum   = (r.carry && sat) ? mask : (full[ACC_W-1:0] & mask);
        return r;
    endfunction

endpackage

// File: rtl/perf_counter_cell.sv
// perf_counter_cell: one event channel with a multi-bit increment, wrap/saturate mode and sticky overflow
//   clk, rst : clock, asynchronous active-high reset
//   en_i     : count this cycle's increment
//   clr_i    : zero count and overflow flag; wins over en_i and discards the increment
//   inc_i    : increment for this cycle
//   cnt_o    : live count
//   ovf_o    : sticky overflow flag
module perf_counter_cell
    import perf_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int INC_W    = 3,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [INC_W-1:0] inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    acc_res_t         nxt;
    logic             unused_hi;

    assign nxt       = acc_add(ACC_W'(cnt_q), ACC_W'(inc_i), CNT_W, SATURATE != 0);
    // Bits above CNT_W are always zero; fold them away.
    assign unused_hi = ^nxt.sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (clr_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (en_i) begin
            cnt_q <= nxt.sum[CNT_W-1:0];
            ovf_q <= ovf_q | nxt.carry;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: multi-channel perf counters with snapshot-and-clear, periodic snapshots and serial dump
//   clk, rst      : clock, asynchronous active-high reset
//   enable_i      : counters and interval timer advance only when high
//   event_inc_i   : per-channel increment, channel i at [i*INC_W +: INC_W]
//   clear_i       : zero live counters, overflow flags and snap_overrun_o
//   snap_req_i    : request a snapshot
//   out_valid_o   : dump beat valid
//   out_ready_i   : sink accepts beat
//   out_ch_o      : channel index of the beat
//   out_cnt_o     : snapshot count of that channel
//   out_ovf_o     : snapshot overflow flag of that channel
//   out_stamp_o   : cycle stamp captured with the snapshot
//   dump_done_o   : one-cycle pulse after the last beat is accepted
//   snap_overrun_o: sticky, a snapshot trigger arrived mid-dump and was dropped
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int NUM_CH   = 16,
    parameter int CNT_W    = 32,
    parameter int INC_W    = 3,
    parameter int SATURATE = 0,
    parameter int INTERVAL = 0,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable_i,
    input  logic [NUM_CH*INC_W-1:0] event_inc_i,
    input  logic                    clear_i,
    input  logic                    snap_req_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [CH_W-1:0]         out_ch_o,
    output logic [CNT_W-1:0]        out_cnt_o,
    output logic                    out_ovf_o,
    output logic [STAMP_W-1:0]      out_stamp_o,
    output logic                    dump_done_o,
    output logic                    snap_overrun_o
);

    localparam int TMR_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

    logic [CNT_W-1:0]   cnt [NUM_CH];
    logic [NUM_CH-1:0]  ovf;
    logic [CNT_W-1:0]   shadow_q [NUM_CH];
    logic [NUM_CH-1:0]  shadow_ovf_q;
    logic [STAMP_W-1:0] stamp_q;
    logic [STAMP_W-1:0] snap_stamp_q;
    logic [TMR_W-1:0]   timer_q;
    dump_state_e        state_q;
    logic [CH_W-1:0]    ch_q;
    logic [CH_W-1:0]    ch_nxt;
    logic [CNT_W-1:0]   out_cnt_q;
    logic               out_ovf_q;
    logic               done_q;
    logic               overrun_q;
    logic               tick;
    logic               trigger;
    logic               last_ch;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_cell
        perf_counter_cell #(
            .CNT_W    (CNT_W),
            .INC_W    (INC_W),
            .SATURATE (SATURATE)
        ) u_cell (
            .clk   (clk),
            .rst   (rst),
            .en_i  (enable_i),
            .clr_i (clear_i),
            .inc_i (event_inc_i[i*INC_W +: INC_W]),
            .cnt_o (cnt[i]),
            .ovf_o (ovf[i])
        );
    end

    assign tick    = (INTERVAL != 0) && enable_i && (timer_q == TMR_W'(INTERVAL - 1));
    assign trigger = snap_req_i | tick;
    assign last_ch = (ch_q == CH_W'(NUM_CH - 1));
    assign ch_nxt  = ch_q + CH_W'(1);

    // Interval timer: only moves while enabled; clear leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            timer_q <= '0;
        else if ((INTERVAL != 0) && enable_i)
            timer_q <= tick ? '0 : timer_q + TMR_W'(1);
    end

    // Free-running cycle stamp, independent of enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stamp_q <= '0;
        else
            stamp_q <= stamp_q + STAMP_W'(1);
    end

    // Snapshot/dump FSM. The beat registers are preloaded so each beat's data
    // is valid in the same cycle the pointer moves to it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ch_q         <= '0;
            out_cnt_q    <= '0;
            out_ovf_q    <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
            snap_stamp_q <= '0;
            shadow_q     <= '{default: '0};
            shadow_ovf_q <= '0;
        end else begin
            done_q    <= 1'b0;
            // A drop in the same cycle as clear must still be recorded.
            overrun_q <= (trigger && state_q == DUMP) ? 1'b1 : clear_i ? 1'b0 : overrun_q;
            case (state_q)
                IDLE: begin
                    if (trigger) begin
                        // Registered live values are pre-update: this cycle's
                        // events land in the next snapshot.
                        shadow_q     <= cnt;
                        shadow_ovf_q <= ovf;
                        snap_stamp_q <= stamp_q;
                        ch_q         <= '0;
                        out_cnt_q    <= cnt[0];
                        out_ovf_q    <= ovf[0];
                        state_q      <= DUMP;
                    end
                end
                DUMP: begin
                    if (out_ready_i) begin
                        if (last_ch) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            ch_q      <= ch_nxt;
                            out_cnt_q <= shadow_q[ch_nxt];
                            out_ovf_q <= shadow_ovf_q[ch_nxt];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid_o    = (state_q == DUMP);
    assign out_ch_o       = ch_q;
    assign out_cnt_o      = out_cnt_q;
    assign out_ovf_o      = out_ovf_q;
    assign out_stamp_o    = snap_stamp_q;
    assign dump_done_o    = done_q;
    assign snap_overrun_o = overrun_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: directed and random checks of wrap, saturate and interval-snapshot bank instances
module tb_perf_counter_bank;

    localparam int N   = 16;
    localparam int CW  = 8;
    localparam int IW  = 3;
    localparam int IV  = 50;
    localparam int LIM = 1 << CW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic clr = 1'b0;
    logic snap = 1'b0;
    logic rdy = 1'b0;
    logic [N*IW-1:0] inc = '0;

    logic w_v, s_v, i_v, w_d, s_d, i_d, w_o, s_o, i_o, w_f, s_f, i_f;
    logic [3:0] w_ch, s_ch, i_ch;
    logic [CW-1:0] w_c, s_c, i_c;
    logic [63:0] w_t, s_t, i_t;

    always #5 clk = ~clk;

    perf_counter_bank #(.NUM_CH(N), .CNT_W(CW), .INC_W(IW), .SATURATE(0), .INTERVAL(0)) dut_w (
        .clk(clk), .rst(rst), .enable_i(en), .event_inc_i(inc), .clear_i(clr), .snap_req_i(snap),
        .out_valid_o(w_v), .out_ready_i(rdy), .out_ch_o(w_ch), .out_cnt_o(w_c), .out_ovf_o(w_f),
        .out_stamp_o(w_t), .dump_done_o(w_d), .snap_overrun_o(w_o));

    perf_counter_bank #(.NUM_CH(N), .CNT_W(CW), .INC_W(IW), .SATURATE(1), .INTERVAL(0)) dut_s (
        .clk(clk), .rst(rst), .enable_i(en), .event_inc_i(inc), .clear_i(clr), .snap_req_i(snap),
        .out_valid_o(s_v), .out_ready_i(rdy), .out_ch_o(s_ch), .out_cnt_o(s_c), .out_ovf_o(s_f),
        .out_stamp_o(s_t), .dump_done_o(s_d), .snap_overrun_o(s_o));

    perf_counter_bank #(.NUM_CH(N), .CNT_W(CW), .INC_W(IW), .SATURATE(0), .INTERVAL(IV)) dut_i (
        .clk(clk), .rst(rst), .enable_i(en), .event_inc_i(inc), .clear_i(clr), .snap_req_i(1'b0),
        .out_valid_o(i_v), .out_ready_i(1'b1), .out_ch_o(i_ch), .out_cnt_o(i_c), .out_ovf_o(i_f),
        .out_stamp_o(i_t), .dump_done_o(i_d), .snap_overrun_o(i_o));

    // Reference model: live counts as plain integers, snapshots as array copies.
    int mw[N], ms[N], shw[N], shs[N], shi[N];
    bit ow[N], os[N], sow[N], sos[N], soi[N];
    longint stamp, sst, sti, en_tot;
    bit dmp, dmpi, ovr, done_e, done_i;
    int ptr, ptri;
    int got_w[N], got_s[N];
    bit got_fw[N];
    longint got_t;
    int hs, dones;
    longint istamps[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_init();
        for (int k = 0; k < N; k++) begin
            mw[k] = 0; ms[k] = 0; ow[k] = 0; os[k] = 0;
            shw[k] = 0; shs[k] = 0; shi[k] = 0; sow[k] = 0; sos[k] = 0; soi[k] = 0;
        end
        stamp = 0; sst = 0; sti = 0; en_tot = 0;
        dmp = 0; dmpi = 0; ovr = 0; done_e = 0; done_i = 0; ptr = 0; ptri = 0;
    endtask

    // Compare DUT outputs against the model, then advance model and DUT one cycle.
    task automatic cycle();
        bit trig_i;
        int e;
        chk("w_valid", 64'(w_v), 64'(dmp));
        chk("s_valid", 64'(s_v), 64'(dmp));
        if (dmp) begin
            chk("w_ch", 64'(w_ch), 64'(ptr));
            chk("w_cnt", 64'(w_c), 64'(shw[ptr]));
            chk("w_ovf", 64'(w_f), 64'(sow[ptr]));
            chk("w_stamp", w_t, 64'(sst));
            chk("s_ch", 64'(s_ch), 64'(ptr));
            chk("s_cnt", 64'(s_c), 64'(shs[ptr]));
            chk("s_ovf", 64'(s_f), 64'(sos[ptr]));
            chk("s_stamp", s_t, 64'(sst));
            got_w[ptr] = int'(w_c);
            got_s[ptr] = int'(s_c);
            got_fw[ptr] = w_f;
            got_t = longint'(w_t);
        end
        chk("w_done", 64'(w_d), 64'(done_e));
        chk("s_done", 64'(s_d), 64'(done_e));
        chk("w_overrun", 64'(w_o), 64'(ovr));
        chk("s_overrun", 64'(s_o), 64'(ovr));
        if (w_d) dones++;
        chk("i_valid", 64'(i_v), 64'(dmpi));
        if (dmpi) begin
            chk("i_ch", 64'(i_ch), 64'(ptri));
            chk("i_cnt", 64'(i_c), 64'(shi[ptri]));
            chk("i_ovf", 64'(i_f), 64'(soi[ptri]));
            chk("i_stamp", i_t, 64'(sti));
            if (ptri == 0) istamps.push_back(longint'(i_t));
        end
        chk("i_done", 64'(i_d), 64'(done_i));
        done_e = dmp && rdy && ptr == N - 1;
        done_i = dmpi && ptri == N - 1;
        if (dmp && rdy) hs++;
        trig_i = en && ((en_tot + 1) % IV == 0);
        if (en) en_tot++;
        if (snap && dmp) ovr = 1;
        else if (clr) ovr = 0;
        if (dmp) begin
            if (rdy) begin
                if (ptr == N - 1) dmp = 0;
                else ptr++;
            end
        end else if (snap) begin
            dmp = 1; ptr = 0; shw = mw; sow = ow; shs = ms; sos = os; sst = stamp;
        end
        if (dmpi) begin
            if (ptri == N - 1) dmpi = 0;
            else ptri++;
        end else if (trig_i) begin
            dmpi = 1; ptri = 0; shi = mw; soi = ow; sti = stamp;
        end
        for (int k = 0; k < N; k++) begin
            e = int'(inc[k*IW +: IW]);
            if (clr) begin
                mw[k] = 0; ms[k] = 0; ow[k] = 0; os[k] = 0;
            end else if (en) begin
                if (mw[k] + e >= LIM) begin mw[k] = mw[k] + e - LIM; ow[k] = 1; end
                else mw[k] = mw[k] + e;
                if (ms[k] + e >= LIM) begin ms[k] = LIM - 1; os[k] = 1; end
                else ms[k] = ms[k] + e;
            end
        end
        stamp++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic set_inc(input int ch, input int val);
        inc = '0;
        inc[ch*IW +: IW] = IW'(val);
    endtask

    task automatic snap_once();
        snap = 1'b1;
        cycle();
        snap = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (dmp && k < 400) begin
            cycle();
            k++;
        end
        chk("dump_finishes", 64'(w_v), 64'd0);
        cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; clr = 1'b0; snap = 1'b0; rdy = 1'b0; inc = '0;
        model_init();
        #2;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int k;
        int c1;
        longint t1;
        logic [CW-1:0] hold_c;
        logic [63:0] hold_t;
        model_init();
        hs = 0; dones = 0;
        #12;
        chk("rst_valid", 64'(w_v), 64'd0);
        chk("rst_ch", 64'(w_ch), 64'd0);
        chk("rst_cnt", 64'(w_c), 64'd0);
        chk("rst_ovf", 64'(w_f), 64'd0);
        chk("rst_stamp", w_t, 64'd0);
        chk("rst_done", 64'(w_d), 64'd0);
        chk("rst_overrun", 64'(w_o), 64'd0);
        chk("rst_i_valid", 64'(i_v), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single channel counting, full 16-beat dump.
        en = 1'b1; rdy = 1'b1;
        set_inc(0, 3);
        run(10);
        inc = '0;
        dones = 0;
        snap_once();
        wait_idle();
        chk("p1_ch0", 64'(got_w[0]), 64'd30);
        chk("p1_ch7", 64'(got_w[7]), 64'd0);
        chk("p1_done_pulses", 64'(dones), 64'd1);

        // Wrap vs saturate.
        set_inc(1, 7);
        run(37);
        inc = '0;
        snap_once();
        wait_idle();
        chk("p2_wrap_cnt", 64'(got_w[1]), 64'd3);
        chk("p2_wrap_ovf", 64'(got_fw[1]), 64'd1);
        chk("p2_sat_cnt", 64'(got_s[1]), 64'd255);
        set_inc(1, 7);
        run(5);
        inc = '0;
        snap_once();
        wait_idle();
        chk("p2_sat_hold", 64'(got_s[1]), 64'd255);

        // Backpressure at channel 2.
        hs = 0;
        snap_once();
        k = 0;
        while (dmp && ptr != 2 && k < 50) begin
            cycle();
            k++;
        end
        rdy = 1'b0;
        hold_c = w_c;
        hold_t = w_t;
        run(5);
        chk("p3_hold_valid", 64'(w_v), 64'd1);
        chk("p3_hold_ch", 64'(w_ch), 64'd2);
        chk("p3_hold_cnt", 64'(w_c), 64'(hold_c));
        chk("p3_hold_stamp", w_t, hold_t);
        rdy = 1'b1;
        wait_idle();
        chk("p3_handshakes", 64'(hs), 64'd16);

        // Atomic read-and-clear.
        do_reset();
        en = 1'b1; rdy = 1'b1;
        set_inc(0, 4);
        run(25);
        inc = '0;
        snap = 1'b1; clr = 1'b1;
        cycle();
        snap = 1'b0; clr = 1'b0;
        wait_idle();
        c1 = got_w[0];
        t1 = got_t;
        snap_once();
        wait_idle();
        chk("p4_first", 64'(c1), 64'd100);
        chk("p4_second", 64'(got_w[0]), 64'd0);
        chk("p4_stamp_grows", 64'(got_t > t1), 64'd1);

        // Dropped snapshot during a dump.
        snap_once();
        run(2);
        snap_once();
        set_inc(0, 1);
        run(4);
        inc = '0;
        chk("p5_overrun", 64'(w_o), 64'd1);
        wait_idle();
        snap_once();
        wait_idle();
        chk("p5_next", 64'(got_w[0]), 64'd4);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        chk("p5_clear", 64'(w_o), 64'd0);

        // Random traffic.
        for (int r = 0; r < 400; r++) begin
            en = ($urandom % 8) != 0;
            for (int c = 0; c < N; c++) inc[c*IW +: IW] = IW'($urandom_range(0, 7));
            clr = ($urandom % 40) == 0;
            snap = ($urandom % 25) == 0;
            rdy = ($urandom % 4) != 0;
            cycle();
        end
        snap = 1'b0; clr = 1'b0; rdy = 1'b1; inc = '0;
        wait_idle();

        // Interval snapshots and reset mid-dump.
        do_reset();
        istamps.delete();
        en = 1'b1; rdy = 1'b1;
        run(130);
        chk("p6_first_stamp", (istamps.size() > 0) ? 64'(istamps[0]) : '1, 64'd49);
        chk("p6_stamp_gap", (istamps.size() > 1) ? 64'(istamps[1] - istamps[0]) : '1, 64'd50);
        k = 0;
        while (!(dmpi && ptri == 5) && k < 100) begin
            cycle();
            k++;
        end
        chk("p6_mid_dump", 64'(i_v), 64'd1);
        rst = 1'b1;
        #1;
        chk("p6_rst_valid", 64'(i_v), 64'd0);
        chk("p6_rst_done", 64'(i_d), 64'd0);
        do_reset();
        en = 1'b1; rdy = 1'b1;
        run(3);
        snap_once();
        wait_idle();
        for (int c = 0; c < N; c++) chk("p6_zero", 64'(got_w[c]), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
